ttl_bus_arbiter: RTL and testbench

//  Round-robin arbiter that shares one tri-state bus between BLOCKS drivers.

---
 rtl/ttl_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_ttl_bus_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttl_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ttl_bus_arbiter
// Purpose  : Round-robin arbiter sharing one tri-state bus between BLOCKS
//            quad bus buffers with active-low enables. Enables are driven
//            one-hot-low, so at most one buffer drives the bus. An all-off
//            turnaround gap separates successive owners so that drivers never
//            overlap.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   BLOCKS      number of requesters/buffers (2..16)
//   TURNAROUND  all-off cycles between successive grants (1..15)
//   HOLD_LIMIT  max consecutive grant cycles when contended (1..255),
//               only meaningful with BUS_ARB_HOLD_LIMIT_EN defined
//   DELAY_RISE  rise delay of Enable_bar/Grant in the board-level model
//   DELAY_FALL  fall delay of Enable_bar/Grant in the board-level model
// Ports
//   Clk          in   1        clock, all state changes on rising edge
//   Reset        in   1        synchronous, active-high
//   Req          in   BLOCKS   active-high bus request per requester
//   Grant        out  BLOCKS   one-hot active-high current owner (registered)
//   Enable_bar   out  BLOCKS   ~Grant, to buffer C pins (0 = drive bus)
//   Grant_index  out  log2     index of owner, valid only when Grant != 0
//   Busy         out  1        high while in GRANT or TURNAROUND
// Configuration macro
//   BUS_ARB_HOLD_LIMIT_EN  defined: a contended owner is forced off the bus
//                          after HOLD_LIMIT consecutive grant cycles.
//                          undefined: the owner keeps the bus until it
//                          drops its request.
// ============================================================================
module ttl_bus_arbiter #(
    parameter int unsigned BLOCKS     = 4,
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned HOLD_LIMIT = 8,
    parameter int unsigned DELAY_RISE = 0,
    parameter int unsigned DELAY_FALL = 0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [BLOCKS-1:0]         Req,
    output logic [BLOCKS-1:0]         Grant,
    output logic [BLOCKS-1:0]         Enable_bar,
    output logic [$clog2(BLOCKS)-1:0] Grant_index,
    output logic                      Busy
);

    localparam int unsigned c_IW = $clog2(BLOCKS);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_GRANT = 2'd1;
    localparam logic [1:0] c_ST_TURN  = 2'd2;

    localparam logic [c_IW-1:0]   c_LAST_IDX = c_IW'(BLOCKS - 1);
    localparam logic [c_IW:0]     c_BLOCKS_W = (c_IW + 1)'(BLOCKS);
    localparam logic [BLOCKS-1:0] c_ONE      = {{(BLOCKS - 1){1'b0}}, 1'b1};
    localparam logic [3:0]        c_TURN     = 4'(TURNAROUND);

    // Rise/fall delays describe the discrete buffer board; the synthesised
    // outputs change only on the clock edge, so they produce no logic here.
    // The same applies to HOLD_LIMIT when the hold-limit feature is off.
    generate
        if ((DELAY_RISE != 0) || (DELAY_FALL != 0)) begin : g_board_delays
        end
`ifndef BUS_ARB_HOLD_LIMIT_EN
        if (HOLD_LIMIT == 0) begin : g_hold_limit_unused
        end
`endif
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [BLOCKS-1:0] r_grant;
    logic [c_IW-1:0]   r_grant_index;
    logic              r_busy;
    logic [c_IW-1:0]   r_pointer;
    logic [3:0]        r_turn_cnt;

    logic [1:0]        w_state_nxt;
    logic [BLOCKS-1:0] w_grant_nxt;
    logic [c_IW-1:0]   w_grant_index_nxt;
    logic              w_busy_nxt;
    logic [c_IW-1:0]   w_pointer_nxt;
    logic [3:0]        w_turn_cnt_nxt;

`ifdef BUS_ARB_HOLD_LIMIT_EN
    localparam logic [7:0] c_HOLD = 8'(HOLD_LIMIT);

    logic [7:0] r_hold_cnt;
    logic [7:0] w_hold_cnt_nxt;
    logic       w_others_req;
`endif

    // ------------------------------------------------------------------------
    // Round-robin search: first set Req at or after r_pointer, wrapping at
    // BLOCKS (which need not be a power of two, hence the explicit wrap).
    // ------------------------------------------------------------------------
    logic              w_win_found;
    logic [c_IW-1:0]   w_win_idx;
    logic [c_IW:0]     w_cand_sum;
    logic [c_IW-1:0]   w_cand;

    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand_sum  = '0;
        w_cand      = '0;
        for (int i = 0; i < BLOCKS; i++) begin
            w_cand_sum = {1'b0, r_pointer} + (c_IW + 1)'(i);
            if (w_cand_sum >= c_BLOCKS_W) begin
                w_cand_sum = w_cand_sum - c_BLOCKS_W;
            end
            w_cand = w_cand_sum[c_IW-1:0];
            if (!w_win_found && Req[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    logic [BLOCKS-1:0] w_win_onehot;
    logic              w_owner_req;
    logic              w_release;
    logic [c_IW-1:0]   w_next_pointer;

    assign w_win_onehot   = c_ONE << w_win_idx;
    assign w_owner_req    = Req[r_grant_index];
    assign w_next_pointer = (r_grant_index == c_LAST_IDX) ? '0
                                                          : r_grant_index + c_IW'(1);

`ifdef BUS_ARB_HOLD_LIMIT_EN
    // Only a competing request can force the owner off; an uncontended owner
    // keeps the bus with its counter parked at HOLD_LIMIT.
    assign w_others_req = |(Req & ~r_grant);
    assign w_release    = !w_owner_req || ((r_hold_cnt >= c_HOLD) && w_others_req);
`else
    assign w_release    = !w_owner_req;
`endif

    // ------------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_grant_index_nxt = r_grant_index;
        w_busy_nxt        = r_busy;
        w_pointer_nxt     = r_pointer;
        w_turn_cnt_nxt    = r_turn_cnt;
`ifdef BUS_ARB_HOLD_LIMIT_EN
        w_hold_cnt_nxt    = r_hold_cnt;
`endif

        case (r_state)
            c_ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt       = c_ST_GRANT;
                    w_grant_nxt       = w_win_onehot;
                    w_grant_index_nxt = w_win_idx;
                    w_busy_nxt        = 1'b1;
`ifdef BUS_ARB_HOLD_LIMIT_EN
                    // The counter includes the cycle the grant is visible.
                    w_hold_cnt_nxt    = 8'd1;
`endif
                end
            end

            c_ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt    = c_ST_TURN;
                    w_grant_nxt    = '0;
                    w_busy_nxt     = 1'b1;
                    w_pointer_nxt  = w_next_pointer;
                    w_turn_cnt_nxt = c_TURN;
                end
`ifdef BUS_ARB_HOLD_LIMIT_EN
                else if (r_hold_cnt < c_HOLD) begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
`endif
            end

            c_ST_TURN: begin
                // The last all-off cycle is also the arbitration cycle, so the
                // bus is idle for exactly TURNAROUND cycles before a regrant.
                if (r_turn_cnt <= 4'd1) begin
                    w_turn_cnt_nxt = 4'd0;
                    if (w_win_found) begin
                        w_state_nxt       = c_ST_GRANT;
                        w_grant_nxt       = w_win_onehot;
                        w_grant_index_nxt = w_win_idx;
                        w_busy_nxt        = 1'b1;
`ifdef BUS_ARB_HOLD_LIMIT_EN
                        w_hold_cnt_nxt    = 8'd1;
`endif
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_turn_cnt_nxt = r_turn_cnt - 4'd1;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= c_ST_IDLE;
            r_grant       <= '0;
            r_grant_index <= '0;
            r_busy        <= 1'b0;
            r_pointer     <= '0;
            r_turn_cnt    <= '0;
`ifdef BUS_ARB_HOLD_LIMIT_EN
            r_hold_cnt    <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_index <= w_grant_index_nxt;
            r_busy        <= w_busy_nxt;
            r_pointer     <= w_pointer_nxt;
            r_turn_cnt    <= w_turn_cnt_nxt;
`ifdef BUS_ARB_HOLD_LIMIT_EN
            r_hold_cnt    <= w_hold_cnt_nxt;
`endif
        end
    end

    assign Grant       = r_grant;
    assign Enable_bar  = ~r_grant;
    assign Grant_index = r_grant_index;
    assign Busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ttl_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ttl_bus_arbiter
// Purpose  : Self-checking bench for ttl_bus_arbiter. A cycle model predicts
//            Grant/Enable_bar/Busy/Grant_index for every driven cycle and
//            queues the prediction; each scenario pops and compares after the
//            clock edge, and adds its own fixed-value checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ttl_bus_arbiter;

    localparam int B  = 4;
    localparam int TA = 1;
    localparam int HL = 8;
    localparam int IW = 2;
    localparam int VW = 2 * B + 1 + IW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [B-1:0]  req = '0;
    logic [B-1:0]  Grant;
    logic [B-1:0]  Enable_bar;
    logic [IW-1:0] Grant_index;
    logic          Busy;

    always #5 clk = ~clk;

    ttl_bus_arbiter #(
        .BLOCKS     (B),
        .TURNAROUND (TA),
        .HOLD_LIMIT (HL),
        .DELAY_RISE (0),
        .DELAY_FALL (0)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .Req         (req),
        .Grant       (Grant),
        .Enable_bar  (Enable_bar),
        .Grant_index (Grant_index),
        .Busy        (Busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [VW-1:0] sb[$];

    // Cycle model: state describing the cycle currently on the outputs.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_gap   = 0;
    int   m_age   = 0;
    logic m_busy  = 1'b0;

    function automatic int pick(input logic [B-1:0] q, input int ptr);
        int k;
        for (int i = 0; i < B; i++) begin
            k = (ptr + i) % B;
            if (q[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [B-1:0] q);
        logic         drop;
        logic         forced;
        logic [B-1:0] own;
        int           w;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_gap = 0; m_age = 0; m_busy = 1'b0;
        end else if (m_owner >= 0) begin
            own = '0;
            own[m_owner] = 1'b1;
            drop = !q[m_owner];
`ifdef BUS_ARB_HOLD_LIMIT_EN
            forced = (m_age >= HL) && ((q & ~own) != '0);
`else
            forced = 1'b0;
`endif
            if (drop || forced) begin
                m_ptr   = (m_owner + 1) % B;
                m_owner = -1;
                m_gap   = TA;
            end else begin
                m_age++;
            end
        end else if (m_gap > 1) begin
            m_gap--;
        end else begin
            m_gap = 0;
            w = pick(q, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_age = 1; m_busy = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    function automatic logic [VW-1:0] model_vec();
        logic [B-1:0]  g;
        logic [IW-1:0] ix;
        g  = '0;
        ix = '0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            ix = IW'(m_owner);
        end
        return {g, ~g, m_busy, ix};
    endfunction

    function automatic logic [VW-1:0] observe();
        logic [IW-1:0] ix;
        ix = (Grant != '0) ? Grant_index : '0;
        return {Grant, Enable_bar, Busy, ix};
    endfunction

    // Drive one cycle, queue the prediction, return just after the edge.
    task automatic step(input logic r, input logic [B-1:0] q);
        @(negedge clk);
        rst = r;
        req = q;
        model_step(r, q);
        sb.push_back(model_vec());
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        logic [VW-1:0] exp, obs;
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 4'b1111);
            exp = sb.pop_front(); obs = observe(); n_cmp++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL reset_model cyc%0d: got %b want %b", c, obs, exp);
            end
            n_cmp++;
            if ({Grant, Enable_bar, Busy} !== {4'b0000, 4'b1111, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold: got G=%b EB=%b busy=%b want G=0000 EB=1111 busy=0",
                         Grant, Enable_bar, Busy);
            end
        end
        step(1'b0, 4'b1111);
        exp = sb.pop_front(); obs = observe(); n_cmp++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL reset_release_model: got %b want %b", obs, exp);
        end
        n_cmp++;
        if ({Grant, Enable_bar, Grant_index} !== {4'b0001, 4'b1110, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_first_grant: got G=%b EB=%b idx=%0d want G=0001 EB=1110 idx=0",
                     Grant, Enable_bar, Grant_index);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_handover();
        logic [VW-1:0] exp, obs;
        step(1'b1, 4'b0000);
        exp = sb.pop_front(); obs = observe(); n_cmp++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL handover_reset: got %b want %b", obs, exp);
        end
        for (int c = 0; c < 6; c++) begin
            step(1'b0, (c < 4) ? 4'b0101 : 4'b0100);
            exp = sb.pop_front(); obs = observe(); n_cmp++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL handover_model cyc%0d: got %b want %b", c, obs, exp);
            end
            if (c == 4) begin
                n_cmp++;
                if (Enable_bar !== 4'b1111) begin
                    n_fail++; $display("FAIL handover_gap: got EB=%b want 1111", Enable_bar);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if ({Grant, Grant_index} !== {4'b0100, 2'd2}) begin
                    n_fail++;
                    $display("FAIL handover_new_owner: got G=%b idx=%0d want G=0100 idx=2",
                             Grant, Grant_index);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_round_robin();
        logic [VW-1:0] exp, obs;
        logic [B-1:0]  q;
        int            owners[$];
        int            gaps[$];
        int            zeros;
        logic          prev_on;
        int            want_own[5];
        want_own = '{0, 1, 2, 3, 0};
        zeros    = 0;
        prev_on  = 1'b0;
        step(1'b1, 4'b0000);
        exp = sb.pop_front(); obs = observe(); n_cmp++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL rr_reset: got %b want %b", obs, exp);
        end
        for (int c = 0; c < 16; c++) begin
            q = 4'b1111;
            if (m_owner >= 0 && m_age >= 2) q[m_owner] = 1'b0;
            step(1'b0, q);
            exp = sb.pop_front(); obs = observe(); n_cmp++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL rr_model cyc%0d: got %b want %b", c, obs, exp);
            end
            if (Grant != '0) begin
                if (!prev_on) begin
                    owners.push_back(int'(Grant_index));
                    gaps.push_back(zeros);
                end
                prev_on = 1'b1;
                zeros   = 0;
            end else begin
                prev_on = 1'b0;
                zeros++;
            end
        end
        n_cmp++;
        if (owners.size() < 5) begin
            n_fail++; $display("FAIL rr_owner_count: got %0d grants want at least 5", owners.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (owners[k] != want_own[k]) begin
                    n_fail++;
                    $display("FAIL rr_owner%0d: got %0d want %0d", k, owners[k], want_own[k]);
                end
                if (k > 0) begin
                    n_cmp++;
                    if (gaps[k] != TA) begin
                        n_fail++;
                        $display("FAIL rr_gap%0d: got %0d off cycles want %0d", k, gaps[k], TA);
                    end
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_hold_limit();
        logic [VW-1:0] exp, obs;
        int            run;
        logic          counting;
        int            want_run;
`ifdef BUS_ARB_HOLD_LIMIT_EN
        want_run = HL;
`else
        want_run = 100;
`endif
        run      = 0;
        counting = 1'b1;
        step(1'b1, 4'b0000);
        exp = sb.pop_front(); obs = observe(); n_cmp++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL hold_reset: got %b want %b", obs, exp);
        end
        for (int c = 0; c < 100; c++) begin
            step(1'b0, 4'b0011);
            exp = sb.pop_front(); obs = observe(); n_cmp++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL hold_model cyc%0d: got %b want %b", c, obs, exp);
            end
            if (counting && Grant === 4'b0001) run++;
            else counting = 1'b0;
        end
        n_cmp++;
        if (run != want_run) begin
            n_fail++; $display("FAIL hold_first_run: got %0d cycles want %0d", run, want_run);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_grant();
        logic [VW-1:0] exp, obs;
        logic [B-1:0]  seq_req[6];
        logic          seq_rst[6];
        seq_req = '{4'b0000, 4'b0010, 4'b0100, 4'b0100, 4'b0110, 4'b0110};
        seq_rst = '{1'b1,    1'b0,    1'b0,    1'b0,    1'b1,    1'b0};
        for (int c = 0; c < 6; c++) begin
            step(seq_rst[c], seq_req[c]);
            exp = sb.pop_front(); obs = observe(); n_cmp++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL midrst_model cyc%0d: got %b want %b", c, obs, exp);
            end
            if (c == 3) begin
                n_cmp++;
                if (Grant !== 4'b0100) begin
                    n_fail++; $display("FAIL midrst_pre_grant: got G=%b want 0100", Grant);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if ({Grant, Enable_bar} !== {4'b0000, 4'b1111}) begin
                    n_fail++;
                    $display("FAIL midrst_cleared: got G=%b EB=%b want G=0000 EB=1111",
                             Grant, Enable_bar);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (Grant !== 4'b0010) begin
                    n_fail++; $display("FAIL midrst_pointer: got G=%b want 0010", Grant);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        logic [VW-1:0] exp, obs;
        logic [B-1:0]  q;
        logic          r;
        q = '0;
        step(1'b1, 4'b0000);
        exp = sb.pop_front(); obs = observe(); n_cmp++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL rand_reset: got %b want %b", obs, exp);
        end
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 3) == 0) q = B'($urandom_range(0, (1 << B) - 1));
            r = ($urandom_range(0, 499) == 0);
            step(r, q);
            exp = sb.pop_front(); obs = observe(); n_cmp++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL rand_model cyc%0d: got %b want %b", c, obs, exp);
            end
            n_cmp++;
            assert ($countones(~Enable_bar) <= 1) else begin
                n_fail++;
                $display("FAIL rand_onehot cyc%0d: got EB=%b want at most one low bit",
                         c, Enable_bar);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_handover();
        test_round_robin();
        test_hold_limit();
        test_reset_mid_grant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
